tx_block: RTL
=============

// Module: tx_block
//
// PURPOSE
// UART-style serial transmitter; the upstream partner of the receive block.
// It accepts a byte through a one-entry holding register and serialises it
// on serial_out as a frame: start bit 0, 8 data bits LSB first, stop bit 1.
// Idle line is high. Bit timing matches the receive block, so serial_out
// can be looped straight into its serial_in.
//
// PARAMETERS
// BIT_PERIOD  10  clocks per serial bit (>=2); frame = 10*BIT_PERIOD clocks
//
// PORTS
// clk          in   1  system clock, all state on rising edge
// n_rst        in   1  asynchronous active-low reset
// tx_data      in   8  byte to send, sampled when tx_load accepted
// tx_load      in   1  load request, one cycle per byte
// tx_full      out  1  holding register occupied
// tx_busy      out  1  frame in progress (FSM not IDLE)
// load_error   out  1  one-cycle pulse: tx_load rejected (holding full)
// frame_done   out  1  one-cycle pulse on last clock of stop bit
// serial_out   out  1  registered serial line, idle high
//
// BEHAVIOUR
// - Reset (async, any time incl. mid-frame):
//   - serial_out=1; tx_full=0, tx_busy=0, load_error=0, frame_done=0.
//   - FSM to IDLE; bit counter and timer cleared; holding data discarded.
// - Holding register:
//   - tx_load accepted when tx_full=0, or when the FSM moves the held byte
//     to the shifter in that same cycle. tx_full then stays 1 and holds the
//     new byte.
//   - Otherwise tx_load is ignored: data is unchanged and load_error pulses
//     the next cycle.
// - FSM states IDLE, START, DATA, STOP. Timer counts 0..BIT_PERIOD-1 per bit.
//   - IDLE: serial_out=1. If tx_full=1: move byte to shifter, clear
//     tx_full, enter START.
//   - START: serial_out=0 for BIT_PERIOD clocks, then DATA with bit index 0.
//   - DATA: serial_out=shifter[0]; shift right at each timer wrap.
//     After 8 bits, enter STOP.
//   - STOP: serial_out=1 for BIT_PERIOD clocks. frame_done=1 on the final
//     clock. Then:
//     - if tx_full=1: move held byte to shifter, go straight to START
//       (no idle gap);
//     - else go to IDLE.
// - Latency: tx_load at edge k -> tx_full=1 after k; serial_out falls
//   after edge k+1. Start bit lasts exactly BIT_PERIOD clocks.
// - tx_busy=1 in START/DATA/STOP, registered with the state.
// - tx_data changes after acceptance must not affect the frame being sent.
// - Timer and bit counter are sized by $clog2; no wrap beyond defined ranges.
//
// TESTING
// 1. Reset -> serial_out=1, tx_full=0, tx_busy=0 for 50 clocks, no pulses.
// 2. Load 8'hA5 in idle -> after 2 clocks line carries
//    0,1,0,1,0,0,1,0,1,1 at 10 clks/bit; frame_done once at clock 101;
//    tx_busy then drops.
// 3. Load 8'h3C, then 8'hC3 mid-frame -> tx_full=1 during first frame.
//    Second start bit begins the clock after the first stop bit ends.
//    Loopback rcv_block shows 8'h3C then 8'hC3 with no framing_error.
// 4. Load while tx_full=1 and mid-frame -> load_error 1-cycle pulse;
//    the originally held byte is the one transmitted.
// 5. Load on the exact IDLE->START transfer cycle -> accepted; tx_full
//    stays 1; both bytes transmitted in order.
// 6. Assert n_rst in DATA of 8'h00 -> serial_out=1 immediately.
//    Next load after release produces a clean full frame.

Source files
------------

// File: rtl/tx_block_if.sv
// Byte-load / serial-line bundle between a byte source and the serial transmitter.
interface tx_block_if;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_full;
    logic       tx_busy;
    logic       load_error;
    logic       frame_done;
    logic       serial_out;

    modport master (
        output tx_data, tx_load,
        input  tx_full, tx_busy, load_error, frame_done, serial_out
    );

    modport slave (
        input  tx_data, tx_load,
        output tx_full, tx_busy, load_error, frame_done, serial_out
    );
endinterface

// File: rtl/tx_block.sv
// UART-style transmitter: one-entry holding register feeding a start/8N/stop
// serialiser with back-to-back frames when the holding register is refilled in time.
module tx_block #(
    parameter int BIT_PERIOD = 10
) (
    input logic       clk,
    input logic       n_rst,
    tx_block_if.slave bus
);

    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [7:0]    shifter, shift_nx;
    logic [7:0]    hold;
    logic          last, move, accept, full_nx, ser_nx;

    assign last = (timer == T_LAST);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        bit_nx   = bit_cnt;
        move     = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = '0;
                if (bus.tx_full) begin
                    move     = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (last) begin
                    timer_nx = '0;
                    bit_nx   = 3'd0;
                    state_nx = DATA;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            DATA: begin
                if (last) begin
                    timer_nx = '0;
                    if (bit_cnt == 3'd7) state_nx = STOP;
                    else                 bit_nx   = bit_cnt + 3'd1;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    timer_nx = '0;
                    // Refilled holding register chains straight into the next start bit.
                    if (bus.tx_full) begin
                        move     = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_comb begin
        shift_nx = shifter;
        if (move)
            shift_nx = hold;
        else if (state == DATA && last)
            shift_nx = {1'b0, shifter[7:1]};
    end

    // Load is allowed into a slot that is being vacated in the same cycle.
    assign accept  = bus.tx_load && (!bus.tx_full || move);
    assign full_nx = accept ? 1'b1 : (move ? 1'b0 : bus.tx_full);

    // The line is registered from the next state so it lines up with state/timer.
    always_comb begin
        case (state_nx)
            START:   ser_nx = 1'b0;
            DATA:    ser_nx = shift_nx[0];
            default: ser_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            timer          <= '0;
            bit_cnt        <= 3'd0;
            bus.tx_full    <= 1'b0;
            bus.tx_busy    <= 1'b0;
            bus.load_error <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.serial_out <= 1'b1;
        end else begin
            state          <= state_nx;
            timer          <= timer_nx;
            bit_cnt        <= bit_nx;
            bus.tx_full    <= full_nx;
            bus.tx_busy    <= (state_nx != IDLE);
            bus.load_error <= bus.tx_load && !accept;
            bus.frame_done <= (state_nx == STOP) && (timer_nx == T_LAST);
            bus.serial_out <= ser_nx;
        end
    end

    always_ff @(posedge clk) begin
        shifter <= shift_nx;
        if (accept) hold <= bus.tx_data;
    end

endmodule
